// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF (read-only) and MEM (load/store),
// MEM priority with bounded IF starvation and a timeout on a hung memory.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int SW = $clog2(MAX_STARVE + 2);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  state_t state, state_nx;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          wr_q, if_win, d_win, tmo_hit, done, idle;
  always_comb begin
    idle     = (state == IDLE);
    if_win   = if_req & (~d_req | ((MAX_STARVE != 0) && (starve_cnt == SW'(MAX_STARVE))));
    d_win    = d_req & ~if_win;
    tmo_hit  = ~idle & ~mem_ack & (tmo_cnt == TW'(TIMEOUT - 1));
    done     = mem_ack | tmo_hit;
    state_nx = idle ? (if_win ? BUSY_IF : d_win ? BUSY_D : IDLE) : done ? IDLE : state;
    busy     = ~idle;
    if_ack   = (state == BUSY_IF) & done;
    d_ack    = (state == BUSY_D) & done;
    err      = tmo_hit;
    if_rdata = ((state == BUSY_IF) && mem_ack) ? mem_rdata : '0;
    d_rdata  = ((state == BUSY_D) && mem_ack && !wr_q) ? mem_rdata : '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wr_q       <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      state   <= state_nx;
      mem_re  <= idle & (if_win | (d_win & ~d_we));
      mem_we  <= idle & d_win & d_we;
      tmo_cnt <= idle ? '0 : tmo_cnt + 1'b1;
      if (idle && (if_win || d_win)) begin
        mem_addr  <= if_win ? if_addr : d_addr;
        mem_wdata <= d_wdata;
        wr_q      <= d_win & d_we;
      end
      // Saturating count of conflicts MEM has won since IF last got the port
      if (idle && if_win)
        starve_cnt <= '0;
      else if (idle && d_win && if_req && starve_cnt != SW'(MAX_STARVE))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule
